if_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage for the 5-stage LoongArch pipeline, between the instruction SRAM-like bus and the ID stage. Issues pipelined fetch requests over an addr_ok/data_ok handshake with up to MAX_OUTSTANDING requests in flight. Buffers returned instructions in a QUEUE_DEPTH-entry queue so that variable-latency memory and ID back-pressure are decoupled. On redirect (branch or exception), flushes all wrong-path state and silently discards responses still in flight.

---
 rtl/if_fetch_queue_pkg.sv | 13 +
 rtl/if_fetch_queue_if.sv | 27 ++
 rtl/if_fetch_queue_fs_sync_fifo.sv | 67 ++++++
 rtl/if_fetch_queue.sv | 113 +++++++++++
 tb/tb_if_fetch_queue.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC default,
// instruction width and the {pc, inst} entry held in the instruction queue.
package if_fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
    localparam int          INST_W           = 32;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetchEntryT;

endpackage

// File: rtl/if_fetch_queue_if.sv
// SRAM-like instruction bus between the fetch stage (master) and memory (slave).
interface if_fetch_queue_if;
    import if_fetch_queue_pkg::*;

    logic              inst_req;
    logic [31:0]       inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [INST_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/if_fetch_queue_fs_sync_fifo.sv
// Generic synchronous FIFO with flush; used for the pending-PC list and the
// instruction queue. A push into a full FIFO is accepted only alongside a pop.
module fs_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_headData,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_count    = r_count;
    assign o_headData = r_mem[r_rdPtr];
    assign w_doPop    = i_pop && !i_flush && !o_empty;
    assign w_doPush   = i_push && !i_flush && (!o_full || i_pop);

    // Storage needs no reset: the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues pipelined fetches under a credit rule that
// guarantees every response has a queue slot, buffers {pc, inst} for ID, and
// drops in-flight wrong-path responses after a redirect.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    if_fetch_queue_if.master   instBus,
    input  logic               ds_allowin,
    output logic               fs_to_ds_valid,
    output logic [31:0]        fs_pc,
    output logic [INST_W-1:0]  fs_inst
);

    localparam int PEND_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int Q_CNT_W    = $clog2(QUEUE_DEPTH + 1);

    logic [31:0]           r_fetchPc;
    logic [PEND_CNT_W-1:0] r_discardCnt;

    logic [PEND_CNT_W-1:0] w_live;
    logic [Q_CNT_W-1:0]    w_qCount;
    logic                  w_pendEmpty;
    logic                  w_pendFull;
    logic                  w_qEmpty;
    logic                  w_qFull;
    logic [31:0]           w_pendPc;
    fetchEntryT            w_newEntry;
    fetchEntryT            w_headEntry;
    logic                  w_creditMem;
    logic                  w_creditQueue;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_keep;
    logic                  w_deqFire;

    // Outstanding slots count both live requests and those already doomed to be dropped.
    assign w_creditMem   = (32'(w_live) + 32'(r_discardCnt)) < 32'(MAX_OUTSTANDING);
    assign w_creditQueue = (32'(w_qCount) + 32'(w_live)) < 32'(QUEUE_DEPTH);
    assign w_issue       = resetn && !redirect_valid && w_creditMem && w_creditQueue
                           && !w_pendFull && !w_qFull;
    assign w_accept      = w_issue && instBus.inst_addr_ok;
    assign w_keep        = instBus.inst_data_ok && (r_discardCnt == '0) && !w_pendEmpty
                           && !redirect_valid;
    assign w_newEntry    = '{pc: w_pendPc, inst: instBus.inst_rdata};

    assign instBus.inst_req  = w_issue;
    assign instBus.inst_addr = r_fetchPc;

    assign fs_to_ds_valid = resetn && !w_qEmpty && !redirect_valid;
    assign fs_pc          = w_qEmpty ? 32'h0 : w_headEntry.pc;
    assign fs_inst        = w_qEmpty ? '0 : w_headEntry.inst;
    assign w_deqFire      = fs_to_ds_valid && ds_allowin;

    fs_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pendFifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_accept),
        .i_pushData (r_fetchPc),
        .i_pop      (w_keep),
        .i_flush    (redirect_valid),
        .o_headData (w_pendPc),
        .o_count    (w_live),
        .o_empty    (w_pendEmpty),
        .o_full     (w_pendFull)
    );

    fs_sync_fifo #(
        .WIDTH ($bits(fetchEntryT)),
        .DEPTH (QUEUE_DEPTH)
    ) u_instQueue (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_keep),
        .i_pushData (w_newEntry),
        .i_pop      (w_deqFire),
        .i_flush    (redirect_valid),
        .o_headData (w_headEntry),
        .o_count    (w_qCount),
        .o_empty    (w_qEmpty),
        .o_full     (w_qFull)
    );

    // Fetch PC advances on accept; a redirect retargets it and converts every live request into a pending discard.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fetchPc    <= RESET_PC;
            r_discardCnt <= '0;
        end else if (redirect_valid) begin
            r_fetchPc    <= redirect_pc;
            r_discardCnt <= PEND_CNT_W'(32'(w_live) + 32'(r_discardCnt)
                                        - 32'(instBus.inst_data_ok));
        end else begin
            if (w_accept) begin
                r_fetchPc <= r_fetchPc + 32'd4;
            end
            if (instBus.inst_data_ok && (r_discardCnt != '0)) begin
                r_discardCnt <= r_discardCnt - PEND_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue: an in-order variable-latency memory
// slave and a queue-based reference model of the fetch stage.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          QD       = 4;
    localparam int          MO       = 2;

    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } entryT;
    typedef struct { logic [31:0] addr; int due; } memReqT;

    logic        clk            = 1'b0;
    logic        resetn         = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        ds_allowin     = 1'b0;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    if_fetch_queue_if bus ();

    if_fetch_queue #(
        .RESET_PC        (RESET_PC),
        .QUEUE_DEPTH     (QD),
        .MAX_OUTSTANDING (MO)
    ) u_dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instBus        (bus),
        .ds_allowin     (ds_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_pc          (fs_pc),
        .fs_inst        (fs_inst)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    entryT       mQueue[$];
    logic [31:0] mPend[$];
    int          mDiscard;
    logic [31:0] mFetchPc;
    memReqT      memQ[$];

    int          latMin, latMax, addrOkPct, allowPct, redirPct;
    bit          redirOnce, redirOnData;
    logic [31:0] redirOncePc;

    int          popCount, busAccCount, firstAcceptCyc, firstValidCyc;
    logic [31:0] popLog[$];
    logic [31:0] lastPopPc;
    bit          havePop;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clearStats();
        popCount = 0; busAccCount = 0; firstAcceptCyc = -1; firstValidCyc = -1;
        popLog.delete();
    endtask

    task automatic doReset(input int n);
        resetn = 1'b0; redirect_valid = 1'b0; ds_allowin = 1'b0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
        repeat (n) begin
            @(negedge clk);
            checkOutput("rst_inst_req", bus.inst_req, 0);
            checkOutput("rst_fs_valid", fs_to_ds_valid, 0);
            checkOutput("rst_fs_pc", fs_pc, 0);
            checkOutput("rst_fs_inst", fs_inst, 0);
            @(posedge clk); #1; cyc++;
        end
        mQueue.delete(); mPend.delete(); memQ.delete();
        mDiscard = 0; mFetchPc = RESET_PC; havePop = 0;
        redirOnce = 0; redirOnData = 0;
        clearStats();
        resetn = 1'b1;
    endtask

    task automatic oneCycle();
        bit          dok, rv, aok, mReq, expValid, popNow, busAcc;
        logic [31:0] rpc;
        entryT       e;
        dok = (memQ.size() > 0) && (memQ[0].due <= cyc);
        rv  = 0;
        rpc = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF8;
        if (redirOnce) begin rv = 1; rpc = redirOncePc; redirOnce = 0; end
        else if (redirOnData && dok) begin rv = 1; rpc = redirOncePc; redirOnData = 0; end
        else if ($urandom_range(99) < redirPct) rv = 1;
        aok = ($urandom_range(99) < addrOkPct);
        bus.inst_data_ok = dok;
        bus.inst_rdata   = dok ? memData(memQ[0].addr) : $urandom;
        bus.inst_addr_ok = aok;
        redirect_valid   = rv;
        redirect_pc      = rpc;
        ds_allowin       = ($urandom_range(99) < allowPct);

        @(negedge clk);
        mReq     = !rv && (mPend.size() + mDiscard < MO) && (mQueue.size() + mPend.size() < QD);
        expValid = (mQueue.size() > 0) && !rv;
        checkOutput("inst_req", bus.inst_req, mReq);
        if (mReq) checkOutput("inst_addr", bus.inst_addr, mFetchPc);
        checkOutput("fs_valid", fs_to_ds_valid, expValid);
        checkOutput("fs_pc", fs_pc, (mQueue.size() > 0) ? mQueue[0].pc : 32'h0);
        checkOutput("fs_inst", fs_inst, (mQueue.size() > 0) ? mQueue[0].inst : 32'h0);
        checkOutput("discard_cnt", 32'(u_dut.r_discardCnt), mDiscard);

        busAcc = bus.inst_req && aok;
        if (busAcc) begin
            busAccCount++;
            if (firstAcceptCyc < 0) firstAcceptCyc = cyc;
        end
        if (fs_to_ds_valid && firstValidCyc < 0) firstValidCyc = cyc;

        popNow = expValid && ds_allowin;
        if (popNow) begin
            if (havePop) checkOutput("pc_stream", fs_pc, lastPopPc + 32'd4);
            lastPopPc = fs_pc; havePop = 1;
            popLog.push_back(fs_pc);
            popCount++;
        end

        if (rv) begin
            mDiscard = mPend.size() + mDiscard - int'(dok);
            mPend.delete(); mQueue.delete();
            mFetchPc = rpc;
            havePop  = 0;
        end else begin
            if (popNow) void'(mQueue.pop_front());
            if (dok) begin
                if (mDiscard > 0) mDiscard--;
                else if (mPend.size() > 0) begin
                    e.pc   = mPend.pop_front();
                    e.inst = memData(e.pc);
                    mQueue.push_back(e);
                end
            end
            if (mReq && aok) begin
                mPend.push_back(mFetchPc);
                mFetchPc += 32'd4;
            end
        end

        if (dok) void'(memQ.pop_front());
        if (busAcc) memQ.push_back('{bus.inst_addr, cyc + int'($urandom_range(latMax, latMin))});
        @(posedge clk); #1; cyc++;
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) oneCycle();
    endtask

    task automatic setKnobs(input int lmin, input int lmax, input int aPct, input int dPct, input int rPct);
        latMin = lmin; latMax = lmax; addrOkPct = aPct; allowPct = dPct; redirPct = rPct;
    endtask

    // Simulation watchdog.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
        setKnobs(1, 1, 100, 100, 0);
        @(posedge clk); #1;

        // Straight-line fetch after reset.
        doReset(3);
        setKnobs(1, 1, 100, 100, 0);
        applyStimulus(12);
        checkOutput("p1_pop_count_ge3", popLog.size() >= 3, 1);
        if (popLog.size() >= 3) begin
            checkOutput("p1_pc0", popLog[0], 32'h1c000000);
            checkOutput("p1_pc1", popLog[1], 32'h1c000004);
            checkOutput("p1_pc2", popLog[2], 32'h1c000008);
        end
        checkOutput("p1_first_accept", firstAcceptCyc >= 0, 1);
        checkOutput("p1_latency", firstValidCyc - firstAcceptCyc, 2);

        // ID stalled: queue fills, then drains.
        doReset(2);
        setKnobs(1, 1, 100, 0, 0);
        applyStimulus(20);
        checkOutput("p2_accepts_stalled", busAccCount, QD);
        setKnobs(1, 1, 100, 100, 0);
        applyStimulus(20);
        checkOutput("p2_first_pop", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, RESET_PC);
        checkOutput("p2_pops", popCount >= 10, 1);

        // Redirect with two requests in flight.
        doReset(2);
        setKnobs(6, 6, 100, 100, 0);
        applyStimulus(2);
        checkOutput("p3_in_flight", busAccCount, 2);
        redirOnce = 1; redirOncePc = 32'h1c000100;
        applyStimulus(1);
        checkOutput("p3_discard_after_redirect", 32'(u_dut.r_discardCnt), 2);
        clearStats();
        setKnobs(1, 1, 100, 100, 0);
        applyStimulus(16);
        checkOutput("p3_first_pc", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, 32'h1c000100);

        // Redirect coinciding with a response.
        doReset(2);
        setKnobs(2, 2, 100, 100, 0);
        redirOnData = 1; redirOncePc = 32'h1c000200;
        applyStimulus(3);
        checkOutput("p4_redirect_fired", redirOnData, 0);
        checkOutput("p4_discard", 32'(u_dut.r_discardCnt), MO - 1);
        checkOutput("p4_queue_empty", fs_pc, 0);
        setKnobs(1, 1, 100, 100, 0);
        clearStats();
        applyStimulus(12);
        checkOutput("p4_first_pc", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, 32'h1c000200);

        // Long random run.
        doReset(2);
        setKnobs(1, 5, 70, 70, 3);
        budget = 0;
        while (popCount < 1000 && budget < 30000) begin
            oneCycle();
            budget++;
        end
        checkOutput("p5_completed_1000", popCount >= 1000, 1);

        // Reset with a full queue and requests in flight.
        doReset(2);
        setKnobs(2, 3, 100, 0, 0);
        applyStimulus(7);
        doReset(3);
        setKnobs(1, 1, 100, 100, 0);
        applyStimulus(10);
        checkOutput("p6_restart_pc", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
